// File: rtl/multi_channel_down_timer_pkg.sv
// Shared encodings for the multi-channel down timer: channel mode values and
// the per-channel state machine encoding.
package multi_channel_down_timer_pkg;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/multi_channel_down_timer_if.sv
// Sequencer-facing bundle of the timer bank: per-channel controls in,
// per-channel count/busy/terminal pulses out.
interface multi_channel_down_timer_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       start;
  logic [CHANNELS-1:0]       stop;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*WIDTH-1:0] limit;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       tc;
  logic                      tc_any;

  modport master (
    output tick, start, stop, mode, limit,
    input  count, busy, tc, tc_any
  );

  modport slave (
    input  tick, start, stop, mode, limit,
    output count, busy, tc, tc_any
  );

endinterface

// File: rtl/down_timer_channel.sv
// One timer channel: IDLE/RUN state, down counter and one-cycle terminal
// pulse, with per-edge priority stop > start > tick.
module down_timer_channel
  import multi_channel_down_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             tc_next_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  // A start with a zero limit is treated as if it never arrived, so a
  // tick on the same edge still acts on a running channel.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start_i && (limit_i != '0)) begin
      state_d = ST_RUN;
      count_d = limit_i;
    end else if ((state_q == ST_RUN) && tick_i) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if ((mode_i == MODE_RELOAD) && (limit_i != '0)) begin
          count_d = limit_i;
        end else begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o   = count_q;
  assign busy_o    = (state_q == ST_RUN);
  assign tc_o      = tc_q;
  assign tc_next_o = tc_d;

endmodule

// File: rtl/multi_channel_down_timer.sv
// Bank of independent down-counting timers for switch dwell/settle timing;
// tc_any is registered from the channels' next-cycle pulses so it lines up with tc.
module multi_channel_down_timer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input logic                       clk,
  input logic                       reset,
  multi_channel_down_timer_if.slave bus
);

  logic [CHANNELS-1:0] tc_next;
  logic                tc_any_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    down_timer_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (bus.tick[i]),
      .start_i  (bus.start[i]),
      .stop_i   (bus.stop[i]),
      .mode_i   (bus.mode[i]),
      .limit_i  (bus.limit[i*WIDTH +: WIDTH]),
      .count_o  (bus.count[i*WIDTH +: WIDTH]),
      .busy_o   (bus.busy[i]),
      .tc_o     (bus.tc[i]),
      .tc_next_o(tc_next[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tc_any_q <= 1'b0;
    end else begin
      tc_any_q <= |tc_next;
    end
  end

  assign bus.tc_any = tc_any_q;

endmodule

// File: tb/tb_multi_channel_down_timer.sv
// Directed bench for the timer bank: a spec-level model checked every cycle
// plus literal expectations for each scenario.
module tb_multi_channel_down_timer;

  localparam int W  = 16;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  bit   compEn     = 1'b0;

  int   mCount[CH];
  bit   mRun[CH];
  bit   mTc[CH];
  bit   mTcAny;

  multi_channel_down_timer_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  multi_channel_down_timer #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference behaviour: each channel is a running flag plus a remaining-tick
  // count; a terminal tick is a tick seen while nothing is left to count.
  always @(posedge clk) begin
    bit anyTc;
    anyTc = 1'b0;
    for (int i = 0; i < CH; i++) begin
      int lim;
      lim    = int'(bus.limit[i*W +: W]);
      mTc[i] = 1'b0;
      if (reset) begin
        mRun[i]   = 1'b0;
        mCount[i] = 0;
      end else if (bus.stop[i]) begin
        mRun[i]   = 1'b0;
        mCount[i] = 0;
      end else if (bus.start[i] && lim > 0) begin
        mRun[i]   = 1'b1;
        mCount[i] = lim;
      end else if (mRun[i] && bus.tick[i]) begin
        if (mCount[i] > 0) begin
          mCount[i] = mCount[i] - 1;
        end else begin
          mTc[i] = 1'b1;
          if (bus.mode[i] && lim > 0) begin
            mCount[i] = lim;
          end else begin
            mRun[i]   = 1'b0;
            mCount[i] = 0;
          end
        end
      end
      anyTc = anyTc | mTc[i];
    end
    mTcAny = anyTc;
  end

  always @(negedge clk) begin
    if (compEn) begin
      for (int i = 0; i < CH; i++) begin
        checkOutput($sformatf("model count[%0d]", i), int'(bus.count[i*W +: W]), mCount[i]);
        checkOutput($sformatf("model busy[%0d]", i), int'(bus.busy[i]), int'(mRun[i]));
        checkOutput($sformatf("model tc[%0d]", i), int'(bus.tc[i]), int'(mTc[i]));
      end
      checkOutput("model tc_any", int'(bus.tc_any), int'(mTcAny));
    end
  end

  task automatic nextEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int ch, input bit st, input bit sp, input bit tk,
                               input bit md, input int lim);
    bus.start[ch]          = st;
    bus.stop[ch]           = sp;
    bus.tick[ch]           = tk;
    bus.mode[ch]           = md;
    bus.limit[ch*W +: W]   = W'(lim);
  endtask

  task automatic clearControls();
    bus.start = '0;
    bus.stop  = '0;
    bus.tick  = '0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.tick  = CH'($urandom);
    bus.start = CH'($urandom);
    bus.stop  = CH'($urandom);
    bus.mode  = CH'($urandom);
    bus.limit = {$urandom, $urandom};

    // Reset held for two edges with random controls
    for (int k = 0; k < 2; k++) begin
      nextEdge();
      compEn    = 1'b1;
      bus.tick  = CH'($urandom);
      bus.start = CH'($urandom);
      checkOutput("reset count", int'(bus.count != '0), 0);
      checkOutput("reset busy", int'(bus.busy), 0);
      checkOutput("reset tc", int'(bus.tc), 0);
      checkOutput("reset tc_any", int'(bus.tc_any), 0);
    end
    clearControls();
    bus.mode  = '0;
    bus.limit = '0;
    reset     = 1'b0;
    nextEdge();

    // One-shot ch0, limit 3, tick every cycle
    applyStimulus(0, 1, 0, 0, 0, 3);
    nextEdge();
    checkOutput("oneshot E0 count", int'(bus.count[0 +: W]), 3);
    checkOutput("oneshot E0 busy", int'(bus.busy[0]), 1);
    applyStimulus(0, 0, 0, 1, 0, 3);
    for (int k = 1; k <= 3; k++) begin
      nextEdge();
      checkOutput($sformatf("oneshot E%0d count", k), int'(bus.count[0 +: W]), 3 - k);
      checkOutput($sformatf("oneshot E%0d tc", k), int'(bus.tc[0]), 0);
    end
    nextEdge();
    checkOutput("oneshot E4 tc", int'(bus.tc[0]), 1);
    checkOutput("oneshot E4 tc_any", int'(bus.tc_any), 1);
    checkOutput("oneshot E4 busy", int'(bus.busy[0]), 0);
    checkOutput("oneshot E4 count", int'(bus.count[0 +: W]), 0);
    clearControls();
    nextEdge();
    checkOutput("oneshot E5 tc", int'(bus.tc[0]), 0);

    // Reload ch1, limit 2, tick every second cycle: tc after E5 and E11
    applyStimulus(1, 1, 0, 0, 1, 2);
    nextEdge();
    checkOutput("reload E0 count", int'(bus.count[W +: W]), 2);
    bus.start[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      bus.tick[1] = (k % 2 == 1);
      nextEdge();
      checkOutput($sformatf("reload E%0d tc", k), int'(bus.tc[1]), int'(k == 5 || k == 11));
      checkOutput($sformatf("reload E%0d busy", k), int'(bus.busy[1]), 1);
    end
    checkOutput("reload E12 count", int'(bus.count[W +: W]), 2);
    clearControls();
    bus.stop[1] = 1'b1;
    nextEdge();
    clearControls();

    // Restart and abort on ch2, limit 5
    applyStimulus(2, 1, 0, 0, 0, 5);
    nextEdge();
    applyStimulus(2, 0, 0, 1, 0, 5);
    nextEdge();
    nextEdge();
    nextEdge();
    checkOutput("restart pre count", int'(bus.count[2*W +: W]), 2);
    bus.start[2] = 1'b1;
    nextEdge();
    checkOutput("restart count", int'(bus.count[2*W +: W]), 5);
    checkOutput("restart tc", int'(bus.tc[2]), 0);
    bus.start[2] = 1'b0;
    nextEdge();
    nextEdge();
    checkOutput("abort pre count", int'(bus.count[2*W +: W]), 3);
    bus.stop[2] = 1'b1;
    nextEdge();
    checkOutput("abort count", int'(bus.count[2*W +: W]), 0);
    checkOutput("abort busy", int'(bus.busy[2]), 0);
    checkOutput("abort tc", int'(bus.tc[2]), 0);
    clearControls();

    // Start with zero limit is ignored
    applyStimulus(3, 1, 0, 1, 0, 0);
    nextEdge();
    checkOutput("zero limit busy", int'(bus.busy[3]), 0);
    checkOutput("zero limit count", int'(bus.count[3*W +: W]), 0);

    // Start and stop together leave the channel idle
    applyStimulus(3, 1, 1, 0, 0, 7);
    nextEdge();
    checkOutput("start+stop busy", int'(bus.busy[3]), 0);
    checkOutput("start+stop count", int'(bus.count[3*W +: W]), 0);
    clearControls();

    // Start coincident with terminal tick reloads without a pulse
    applyStimulus(0, 1, 0, 0, 1, 1);
    nextEdge();
    applyStimulus(0, 0, 0, 1, 1, 1);
    nextEdge();
    checkOutput("start+tc pre count", int'(bus.count[0 +: W]), 0);
    bus.start[0] = 1'b1;
    nextEdge();
    checkOutput("start+tc count", int'(bus.count[0 +: W]), 1);
    checkOutput("start+tc tc", int'(bus.tc[0]), 0);
    checkOutput("start+tc busy", int'(bus.busy[0]), 1);
    clearControls();
    bus.stop[0] = 1'b1;
    nextEdge();
    clearControls();

    // Reset at count 1 clears everything without a pulse
    applyStimulus(2, 1, 0, 0, 1, 2);
    nextEdge();
    applyStimulus(2, 0, 0, 1, 1, 2);
    nextEdge();
    checkOutput("reset mid pre count", int'(bus.count[2*W +: W]), 1);
    reset = 1'b1;
    nextEdge();
    checkOutput("reset mid count", int'(bus.count[2*W +: W]), 0);
    checkOutput("reset mid busy", int'(bus.busy[2]), 0);
    reset = 1'b0;
    nextEdge();
    checkOutput("reset mid tc", int'(bus.tc[2]), 0);
    checkOutput("reset mid tc_any", int'(bus.tc_any), 0);
    clearControls();
    bus.limit = '0;
    nextEdge();

    // Independent reload channels: ch0 limit 1, ch3 limit 4
    applyStimulus(0, 1, 0, 0, 1, 1);
    applyStimulus(3, 1, 0, 0, 1, 4);
    nextEdge();
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(3, 0, 0, 1, 1, 4);
    for (int k = 1; k <= 20; k++) begin
      nextEdge();
      checkOutput($sformatf("indep E%0d tc0", k), int'(bus.tc[0]), int'(k % 2 == 0));
      checkOutput($sformatf("indep E%0d tc3", k), int'(bus.tc[3]), int'(k % 5 == 0));
      checkOutput($sformatf("indep E%0d tc_any", k), int'(bus.tc_any),
                  int'((k % 2 == 0) || (k % 5 == 0)));
    end
    clearControls();
    bus.stop = '1;
    nextEdge();
    clearControls();
    nextEdge();
    compEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_channel_down_timer.md
# multi_channel_down_timer

Bank of CHANNELS independent, programmable down-counting timers for photonic-switch dwell and settle timing. Each channel is started from a per-channel limit and decrements on its own tick enable. On expiry it emits a one-cycle terminal pulse and either stops (one-shot) or reloads (auto-reload). It sits between the switch sequencer, which issues start/stop and mode, and the switch drivers and sequencer FSM, which consume the terminal pulses.

## Interface
- WIDTH, 16: counter width per channel.
- CHANNELS, 4: number of independent timer channels.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- tick  in  CHANNELS  per-channel decrement enable.
- start  in  CHANNELS  per-channel start/restart request.
- stop  in  CHANNELS  per-channel abort request.
- mode  in  CHANNELS  per-channel mode: 0 = one-shot, 1 = auto-reload.
- limit  in  CHANNELS*WIDTH  per-channel load value; channel i at bits [i*WIDTH +: WIDTH].
- count  out  CHANNELS*WIDTH  current count per channel, same packing.
- busy  out  CHANNELS  channel in RUN.
- tc  out  CHANNELS  one-cycle terminal-count pulse.
- tc_any  out  1  registered OR of all tc bits, coincident with tc.

## Operation
- Each channel is independent and has two states, IDLE and RUN.
- Priority per channel, per edge: reset > stop > start > tick.
- reset: every channel goes to IDLE, with count=0, busy=0, tc=0 and tc_any=0.
- stop[i]:
  - Channel goes to IDLE, count=0, busy=0.
  - No tc pulse.
  - Legal in either state.
- start[i] with limit[i] != 0, from any state:
  - count <= limit[i], state goes to RUN, busy=1.
  - A start while in RUN restarts the channel and emits no tc.
- start[i] with limit[i] == 0: ignored, with no state or count change.
- RUN, tick[i] with count > 0: count <= count-1.
- RUN, tick[i] with count == 0 (terminal tick):
  - tc[i]=1 for exactly one cycle.
  - Reload mode: count <= limit[i], sampled live at that edge. If limit[i] is now 0, the channel goes to IDLE instead.
  - One-shot mode: channel goes to IDLE with count=0, busy=0.
- IDLE: tick is ignored and count holds at 0.
- Period from start to tc is limit+1 ticks. In reload mode, tc recurs every limit+1 ticks.
- mode[i] is sampled at the terminal tick; changing it mid-run is legal.
- count arithmetic is unsigned WIDTH bits and never wraps below 0.

## Timing
- All outputs are registered.
- count/busy update at the edge where start, stop or tick is sampled.
- tc[i] is high during the cycle following the edge that consumed the terminal tick; it is never high for two consecutive cycles unless consecutive terminal ticks occur (reload with limit=0 is impossible, so the minimum spacing is 2 cycles).
- tc_any is asserted in the same cycle as any tc bit.
- Simultaneous start and terminal tick: the start wins, the count reloads from limit, and there is no tc.
- Simultaneous stop and terminal tick: the stop wins and there is no tc.
- A reset asserted mid-run clears everything at that edge, and no tc is emitted.

## Structure
- Package multi_channel_down_timer_pkg holds:
  - MODE_ONESHOT=1'b0 and MODE_RELOAD=1'b1.
  - The state encoding ST_IDLE/ST_RUN.
- Sub-module down_timer_channel (parameter WIDTH) implements one channel's FSM, count, busy and tc.
- The top level instantiates CHANNELS copies via generate, slices the packed buses, and registers tc_any.

## Test plan
- Reset behaviour: hold reset 2 cycles with random inputs -> count=0, busy=0, tc=0 and tc_any=0 on all channels.
- One-shot, tick every cycle: ch0 with limit=3, mode=0, start at edge E0.
  - Expected count sequence: 3, 2, 1, 0.
  - tc[0] high only in the cycle after E4.
  - busy[0] drops at E4.
- Reload, tick every 2nd cycle: ch1 with limit=2, mode=1 -> tc[1] pulses every 6 cycles, count cycles 2, 1, 0, 2, and busy stays 1.
- Restart and abort on ch2 with limit=5:
  - Start again with count=2 -> count reloads to 5 with no tc.
  - Later stop with count=3 -> IDLE, count=0, and no tc ever.
- Boundary conditions:
  - start with limit=0 -> ignored.
  - start and stop in the same cycle -> IDLE.
  - start coincident with terminal tick -> reload, no tc.
  - reset at count=1 -> all cleared, no tc.
- Independence: ch0 with limit=1 and ch3 with limit=4, both reload, tick every cycle.
  - tc[0] fires every 2 cycles and tc[3] every 5 cycles.
  - tc_any is the OR of the two, cycle-exact, with no cross-channel interference.
